seq_mult_ctrl: RTL and testbench



---
 rtl/seq_mult_ctrl.sv | 111 +++++++++++
 tb/tb_seq_mult_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/seq_mult_ctrl.sv
// rtl/seq_mult_ctrl.sv - sequencer for the signed shift-add multiplier datapath
module seq_mult_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign_a,
  input  logic             sign_b,
  input  logic             mplr_lsb,
  input  logic             mplr_zero,
  output logic             load,
  output logic             add_en,
  output logic             shift_en,
  output logic             neg_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] iter_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ITER = 3'd2,
    S_SIGN = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] iter_cnt_q;
  logic [CNT_W-1:0] iter_cnt_d;
  logic             sign_diff_q;
  logic             load_q;
  logic             busy_q;
  logic             neg_q;
  logic             done_q;
  logic             in_iter;

  assign iter_cnt_d = iter_cnt_q - CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      iter_cnt_q  <= '0;
      sign_diff_q <= 1'b0;
      load_q      <= 1'b0;
      busy_q      <= 1'b0;
      neg_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_LOAD;
            load_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_LOAD: begin
          state_q     <= S_ITER;
          load_q      <= 1'b0;
          sign_diff_q <= sign_a ^ sign_b;
          iter_cnt_q  <= CNT_W'(WIDTH);
        end
        S_ITER: begin
          // A zero multiplier ends the loop without consuming an iteration.
          if (mplr_zero) begin
            state_q <= S_SIGN;
            neg_q   <= sign_diff_q;
          end else begin
            iter_cnt_q <= iter_cnt_d;
            if (iter_cnt_q == CNT_W'(1)) begin
              state_q <= S_SIGN;
              neg_q   <= sign_diff_q;
            end
          end
        end
        S_SIGN: begin
          state_q <= S_DONE;
          neg_q   <= 1'b0;
          done_q  <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          load_q  <= 1'b0;
          busy_q  <= 1'b0;
          neg_q   <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // add/shift follow the live multiplier bits, so they stay combinational.
  assign in_iter  = (state_q == S_ITER);
  assign shift_en = in_iter & ~mplr_zero;
  assign add_en   = in_iter & ~mplr_zero & mplr_lsb;

  assign load     = load_q;
  assign busy     = busy_q;
  assign neg_en   = neg_q;
  assign done     = done_q;
  assign iter_cnt = iter_cnt_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// tb/tb_seq_mult_ctrl.sv - directed bench for seq_mult_ctrl
module tb_seq_mult_ctrl;
  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst, start, sign_a, sign_b, mplr_lsb, mplr_zero;
  logic             load, add_en, shift_en, neg_en, busy, done;
  logic [CNT_W-1:0] iter_cnt;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int viol = 0;

  seq_mult_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .sign_a(sign_a), .sign_b(sign_b),
    .mplr_lsb(mplr_lsb), .mplr_zero(mplr_zero), .load(load), .add_en(add_en),
    .shift_en(shift_en), .neg_en(neg_en), .busy(busy), .done(done),
    .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (($countones({load, shift_en, neg_en, done}) > 1) || (add_en && !shift_en))
      viol <= viol + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation from an IDLE cycle; zero_at = ITER index where mplr_zero rises.
  task automatic run_op(input logic sa, input logic sb, input logic [7:0] pat,
                        input int zero_at, input logic poke, input int exp_lat,
                        input int exp_cnt_end, input string nm);
    int k;
    int exp_cnt;
    int d0;
    logic z;
    d0 = done_cnt;
    start = 1'b1; sign_a = sa; sign_b = sb; mplr_lsb = 1'b0; mplr_zero = 1'b0;
    tick();
    k = cyc;
    start = 1'b0; #1;
    check({nm, "_load"}, {28'd0, load, busy, shift_en, done}, 32'b1100);
    exp_cnt = WIDTH;
    for (int i = 0; i < WIDTH; i++) begin
      tick();
      z = (i >= zero_at);
      start = poke; mplr_lsb = pat[i]; mplr_zero = z; #1;
      check({nm, "_itcnt"}, 32'(iter_cnt), 32'(exp_cnt));
      check({nm, "_shift"}, 32'(shift_en), 32'(!z));
      check({nm, "_add"}, 32'(add_en), 32'(pat[i] && !z));
      if (z) break;
      exp_cnt--;
    end
    tick();
    start = poke; mplr_zero = 1'b0; mplr_lsb = 1'b0; #1;
    check({nm, "_neg"}, {30'd0, neg_en, shift_en}, {30'd0, sa ^ sb, 1'b0});
    check({nm, "_signcnt"}, 32'(iter_cnt), 32'(exp_cnt_end));
    tick();
    start = 1'b0; #1;
    check({nm, "_done"}, {30'd0, done, busy}, 32'b11);
    check({nm, "_lat"}, 32'(cyc - k + 1), 32'(exp_lat));
    tick();
    #1;
    check({nm, "_idle"}, {29'd0, done, busy, load}, 32'd0);
    check({nm, "_idlecnt"}, 32'(iter_cnt), 32'(exp_cnt_end));
    check({nm, "_ndone"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int d0;
    int nd;
    int dcyc[3];
    logic p1, p2;
    rst = 1'b1; start = 1'b0; sign_a = 1'b0; sign_b = 1'b0;
    mplr_lsb = 1'b0; mplr_zero = 1'b0;
    tick(); tick();
    check("reset_outs", {26'd0, load, add_en, shift_en, neg_en, busy, done}, 32'd0);
    check("reset_cnt", 32'(iter_cnt), 32'd0);
    rst = 1'b0; #1;

    run_op(1'b0, 1'b0, 8'b0000_0101, 8, 1'b0, 11, 0, "mult5");
    run_op(1'b1, 1'b0, 8'b0000_0101, 8, 1'b0, 11, 0, "negab");
    run_op(1'b1, 1'b1, 8'b0000_0011, 8, 1'b0, 11, 0, "bothneg");
    run_op(1'b0, 1'b0, 8'b0000_0111, 2, 1'b0, 6, 6, "early");
    run_op(1'b0, 1'b1, 8'b1010_0101, 8, 1'b1, 11, 0, "poke");

    // Reset while in the fourth ITER cycle (iter_cnt = 5).
    start = 1'b1; mplr_lsb = 1'b1; mplr_zero = 1'b0;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #1;
    check("midrst_cnt5", 32'(iter_cnt), 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    check("midrst_outs", {26'd0, load, add_en, shift_en, neg_en, busy, done}, 32'd0);
    check("midrst_cnt", 32'(iter_cnt), 32'd0);
    d0 = done_cnt;
    repeat (15) tick();
    check("midrst_nodone", 32'(done_cnt - d0), 32'd0);

    // start held high: three back-to-back operations.
    start = 1'b1; mplr_lsb = 1'b0; mplr_zero = 1'b0; sign_a = 1'b0; sign_b = 1'b0;
    nd = 0; p1 = 1'b0; p2 = 1'b0;
    for (int c = 0; c < 60 && nd < 3; c++) begin
      tick();
      #1;
      if (p1) check("b2b_idle", {30'd0, busy, load}, 32'd0);
      if (p2) check("b2b_reload", 32'(load), 32'd1);
      p2 = p1;
      p1 = done;
      if (done) begin
        dcyc[nd] = cyc;
        nd++;
        if (nd == 3) start = 1'b0;
      end
    end
    check("b2b_count", 32'(nd), 32'd3);
    if (nd == 3) begin
      check("b2b_gap1", 32'(dcyc[1] - dcyc[0]), 32'(WIDTH + 4));
      check("b2b_gap2", 32'(dcyc[2] - dcyc[1]), 32'(WIDTH + 4));
    end
    repeat (3) tick();
    check("b2b_end_idle", 32'(busy), 32'd0);

    check("exclusive_outs", 32'(viol), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
